// File: rtl/gp_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package gp_pkg;

  typedef struct packed {
    logic g;
    logic p;
  } gp_pair_t;

  function automatic int gp_clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Rank k (1-based) sits after this prefix level; level 0 is the bitwise g/p stage.
  function automatic int gp_rank_level(input int rank, input int levels, input int stages);
    return (rank * levels) / stages;
  endfunction

endpackage

// File: rtl/gp_prefix_level.sv
// One combinational Kogge-Stone level: every bit at or above DIST merges with
// the group DIST positions below it.
module gp_prefix_level
  import gp_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DIST  = 1
) (
  input  gp_pair_t [WIDTH-1:0] gp_i,
  output gp_pair_t [WIDTH-1:0] gp_o
);

  always_comb begin
    gp_o = gp_i;
    for (int i = DIST; i < WIDTH; i++) begin
      gp_o[i].g = gp_i[i].g | (gp_i[i].p & gp_i[i-DIST].g);
      gp_o[i].p = gp_i[i].p & gp_i[i-DIST].p;
    end
  end

endmodule

// File: rtl/pipelined_prefix_adder.sv
// Kogge-Stone adder/subtractor with a configurable number of valid/ready
// pipeline ranks spread evenly across the prefix levels.
module pipelined_prefix_adder
  import gp_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int L = gp_clog2(WIDTH);

  // Zero-based index of the intermediate rank sitting after level lv, or -1.
  function automatic int rank_at(input int lv);
    int r;
    r = -1;
    for (int k = 1; k < STAGES; k++) begin
      if (gp_rank_level(k, L, STAGES) == lv) r = k - 1;
    end
    return r;
  endfunction

  logic [STAGES-1:0] vld_q, vld_d, adv, load, src_vld, dload;

  // Ready ripples backwards from the output rank so bubbles collapse under stall.
  always_comb begin
    adv     = '0;
    load    = '0;
    src_vld = '0;
    adv[STAGES-1]  = vld_q[STAGES-1] & out_ready;
    load[STAGES-1] = ~vld_q[STAGES-1] | adv[STAGES-1];
    for (int r = STAGES - 2; r >= 0; r--) begin
      adv[r]  = vld_q[r] & load[r+1];
      load[r] = ~vld_q[r] | adv[r];
    end
    src_vld[0] = in_valid;
    for (int r = 1; r < STAGES; r++) begin
      src_vld[r] = vld_q[r-1];
    end
    dload = load & src_vld;
    vld_d = (load & src_vld) | (~load & vld_q);
  end

  assign in_ready  = load[0] & ~rst;
  assign out_valid = vld_q[STAGES-1];

  logic [WIDTH-1:0]     b_eff, p_in;
  logic                 cin_eff;
  gp_pair_t [WIDTH-1:0] gp_in;

  always_comb begin
    b_eff   = sub ? ~b : b;
    cin_eff = sub | cin;
    p_in    = a ^ b_eff;
    gp_in   = '0;
    for (int i = 0; i < WIDTH; i++) begin
      gp_in[i].p = p_in[i];
      gp_in[i].g = a[i] & b_eff[i];
    end
    // Carry-in enters as part of the bit-0 generate.
    gp_in[0].g = (a[0] & b_eff[0]) | (p_in[0] & cin_eff);
  end

  gp_pair_t [WIDTH-1:0] gp_c  [L+1];
  gp_pair_t [WIDTH-1:0] gp_s  [L];
  logic     [WIDTH-1:0] p0_c  [L+1];
  logic     [WIDTH-1:0] p0_s  [L];
  logic                 cin_c [L+1];
  logic                 cin_s [L];

  assign gp_c[0]  = gp_in;
  assign p0_c[0]  = p_in;
  assign cin_c[0] = cin_eff;

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int R = rank_at(lv);

    if (R >= 0) begin : g_reg
      gp_pair_t [WIDTH-1:0] gp_q;
      logic     [WIDTH-1:0] p0_q;
      logic                 cin_q;

      always_ff @(posedge clk) begin
        if (dload[R]) begin
          gp_q  <= gp_c[lv];
          p0_q  <= p0_c[lv];
          cin_q <= cin_c[lv];
        end
      end

      assign gp_s[lv]  = gp_q;
      assign p0_s[lv]  = p0_q;
      assign cin_s[lv] = cin_q;
    end else begin : g_thru
      assign gp_s[lv]  = gp_c[lv];
      assign p0_s[lv]  = p0_c[lv];
      assign cin_s[lv] = cin_c[lv];
    end

    gp_prefix_level #(
      .WIDTH (WIDTH),
      .DIST  (1 << lv)
    ) u_level (
      .gp_i (gp_s[lv]),
      .gp_o (gp_c[lv+1])
    );

    assign p0_c[lv+1]  = p0_s[lv];
    assign cin_c[lv+1] = cin_s[lv];
  end

  logic [WIDTH-1:0] g_fin, sum_d, sum_q;
  logic             cout_d, ovf_d, cout_q, ovf_q;

  always_comb begin
    g_fin = '0;
    for (int i = 0; i < WIDTH; i++) begin
      g_fin[i] = gp_c[L][i].g;
    end
    sum_d  = p0_c[L] ^ {g_fin[WIDTH-2:0], cin_c[L]};
    cout_d = g_fin[WIDTH-1];
    ovf_d  = g_fin[WIDTH-1] ^ g_fin[WIDTH-2];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      vld_q <= vld_d;
      if (dload[STAGES-1]) begin
        sum_q  <= sum_d;
        cout_q <= cout_d;
        ovf_q  <= ovf_d;
      end
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_pipelined_prefix_adder.sv
// Directed and randomized checks of pipelined_prefix_adder across several
// width/depth configurations against an arithmetic reference model.
module tb_pipelined_prefix_adder;

  localparam int NCFG = 9;
  localparam int CW [NCFG] = '{32, 2, 2, 19, 19, 32, 32, 64, 64};
  localparam int CS [NCFG] = '{ 2, 1, 2,  1,  6,  1,  6,  1,  7};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst;
  logic [63:0]     a_s, b_s;
  logic            cin_s, sub_s;
  logic [NCFG-1:0] iv, ordy, irdy, ovld, cout_w, ovf_w;
  logic [63:0]     sum_w [NCFG];

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q [NCFG][$];

  for (genvar c = 0; c < NCFG; c++) begin : g_dut
    localparam int W = CW[c];
    logic [W-1:0] s;

    pipelined_prefix_adder #(
      .WIDTH  (W),
      .STAGES (CS[c])
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv[c]),
      .in_ready  (irdy[c]),
      .a         (a_s[W-1:0]),
      .b         (b_s[W-1:0]),
      .cin       (cin_s),
      .sub       (sub_s),
      .out_valid (ovld[c]),
      .out_ready (ordy[c]),
      .sum       (s),
      .cout      (cout_w[c]),
      .ovf       (ovf_w[c])
    );

    assign sum_w[c] = 64'(s);
  end

  // Returns {ovf, cout, sum zero-extended to 64 bits}.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a, input logic [63:0] b,
                                            input logic cin, input logic sub);
    logic [64:0] m, aa, bb, r;
    logic        co, sa, sb, sr, ov;
    m  = (65'd1 << w) - 65'd1;
    aa = {1'b0, a} & m;
    bb = {1'b0, b} & m;
    if (sub) begin
      r  = (aa - bb) & m;
      co = (aa >= bb);
    end else begin
      r  = aa + bb + 65'(cin);
      co = r[w];
      r  = r & m;
    end
    sa = aa[w-1];
    sb = bb[w-1];
    sr = r[w-1];
    ov = sub ? ((sa != sb) && (sr != sa)) : ((sa == sb) && (sr != sa));
    return {ov, co, r[63:0]};
  endfunction

  task automatic chk(input string tag, input logic [65:0] obs, input logic [65:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [65:0] obs_of(input int c);
    return {ovf_w[c], cout_w[c], sum_w[c]};
  endfunction

  task automatic observe(input int c, input string tag);
    if (ovld[c]) begin
      if (exp_q[c].size() == 0) begin
        chk({tag, "_spurious"}, 66'(ovld[c]), 66'd0);
      end else begin
        chk(tag, obs_of(c), exp_q[c][0]);
        if (ordy[c]) void'(exp_q[c].pop_front());
      end
    end
  endtask

  task automatic accept(input int c);
    if (iv[c] && irdy[c]) exp_q[c].push_back(ref_model(CW[c], a_s, b_s, cin_s, sub_s));
  endtask

  logic [63:0] opa [8];
  logic [63:0] opb [8];
  logic        opc [8];
  logic        ops [8];
  int          sent;
  int          got;

  initial begin
    rst   = 1'b1;
    iv    = '0;
    ordy  = '1;
    a_s   = '0;
    b_s   = '0;
    cin_s = 1'b0;
    sub_s = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("rst_out_valid_c%0d", c), 66'(ovld[c]), 66'd0);
      chk($sformatf("rst_in_ready_c%0d", c), 66'(irdy[c]), 66'd0);
      chk($sformatf("rst_result_c%0d", c), obs_of(c), 66'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", 66'(irdy[0]), 66'd1);

    // All-ones plus one wraps to zero with carry out
    a_s = 64'hFFFF_FFFF; b_s = 64'h1; cin_s = 1'b0; sub_s = 1'b0; iv[0] = 1'b1;
    @(negedge clk);
    chk("d1_in_ready", 66'(irdy[0]), 66'd1);
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("d1_lat1_valid", 66'(ovld[0]), 66'd0);
    @(posedge clk);
    @(negedge clk);
    chk("d1_lat2_valid", 66'(ovld[0]), 66'd1);
    chk("d1_result", obs_of(0), {1'b0, 1'b1, 64'h0});
    @(negedge clk);
    chk("d1_drained", 66'(ovld[0]), 66'd0);

    // Most-negative minus one overflows; cin must be ignored in subtract mode
    @(posedge clk); #1;
    a_s = 64'h8000_0000; b_s = 64'h1; cin_s = 1'b1; sub_s = 1'b1; iv[0] = 1'b1;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("d2_valid", 66'(ovld[0]), 66'd1);
    chk("d2_result", obs_of(0), {1'b1, 1'b1, 64'h7FFF_FFFF});
    @(posedge clk); #1;

    // Eight back-to-back beats against a stalled output
    for (int i = 0; i < 8; i++) begin
      opa[i] = 64'($urandom);
      opb[i] = 64'($urandom);
      opc[i] = 1'($urandom);
      ops[i] = 1'($urandom);
    end
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(posedge clk); #1;
      ordy[0] = 1'b0;
      iv[0]   = 1'b1;
      a_s = opa[sent]; b_s = opb[sent]; cin_s = opc[sent]; sub_s = ops[sent];
      @(negedge clk);
      if (cyc == 5) begin
        chk("bp_in_ready_low", 66'(irdy[0]), 66'd0);
        chk("bp_out_valid", 66'(ovld[0]), 66'd1);
      end
      observe(0, "bp_hold");
      if (iv[0] && irdy[0]) begin
        accept(0);
        sent++;
      end
    end
    chk("bp_accepted", 66'(sent), 66'(CS[0]));

    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      ordy[0] = 1'b1;
      iv[0]   = (sent < 8);
      if (sent < 8) begin
        a_s = opa[sent]; b_s = opb[sent]; cin_s = opc[sent]; sub_s = ops[sent];
      end
      @(negedge clk);
      chk("tp_out_valid", 66'(ovld[0]), 66'd1);
      if (ovld[0]) got++;
      observe(0, "tp_data");
      if (iv[0] && irdy[0]) begin
        accept(0);
        sent++;
      end
    end
    chk("tp_results", 66'(got), 66'd8);
    chk("tp_drained", 66'(exp_q[0].size()), 66'd0);

    // Reset with two beats in flight
    @(posedge clk); #1;
    iv[0] = 1'b1; ordy[0] = 1'b0;
    a_s = 64'h1234_5678; b_s = 64'h1111_1111; cin_s = 1'b0; sub_s = 1'b0;
    @(posedge clk); #1;
    a_s = 64'h0BAD_F00D;
    @(posedge clk); #1;
    iv[0] = 1'b0;
    @(negedge clk);
    chk("rf_valid_before", 66'(ovld[0]), 66'd1);
    #2 rst = 1'b1;
    #1;
    chk("rf_async_valid", 66'(ovld[0]), 66'd0);
    chk("rf_async_ready", 66'(irdy[0]), 66'd0);
    chk("rf_async_result", obs_of(0), 66'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    ordy[0] = 1'b1;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      chk("rf_no_stale", 66'(ovld[0]), 66'd0);
    end

    // Random sweep over every configuration with random backpressure
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk); #1;
      a_s   = {$urandom, $urandom};
      b_s   = {$urandom, $urandom};
      cin_s = 1'($urandom);
      sub_s = 1'($urandom);
      case ($urandom_range(7))
        0: a_s = '1;
        1: b_s = '1;
        2: b_s = a_s;
        3: begin a_s = '0; b_s = '0; end
        default: ;
      endcase
      for (int c = 0; c < NCFG; c++) begin
        iv[c]   = ($urandom_range(3) != 0);
        ordy[c] = ($urandom_range(2) != 0);
      end
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) begin
        observe(c, $sformatf("rand_c%0d", c));
        accept(c);
      end
    end

    for (int cyc = 0; cyc < 24; cyc++) begin
      @(posedge clk); #1;
      iv   = '0;
      ordy = '1;
      @(negedge clk);
      for (int c = 0; c < NCFG; c++) observe(c, $sformatf("drain_c%0d", c));
    end
    for (int c = 0; c < NCFG; c++) begin
      chk($sformatf("drain_empty_c%0d", c), 66'(exp_q[c].size()), 66'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
